// File: rtl/axis_pattern_checker_if.sv
// AXI-Stream link bundle between a packet source and the pattern checker.
// The master drives data/valid/last, the slave returns ready.
interface axis_pattern_checker_if #(
   parameter int DATA_WIDTH = 16
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;

   modport master (
      output tdata,
      output tvalid,
      output tlast,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      input  tlast,
      output tready
   );
endinterface

// File: rtl/axis_pattern_checker.sv
// AXI-Stream sink that checks incrementing-pattern packets of a programmed length and counts results.
// Optional backpressure generator: define AXIS_CHK_THROTTLE_EN to gate s_tready with an LFSR.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | between packets; the next accepted beat starts a packet at seed
// ST_RECV  | inside a packet; every beat is compared against the expected word
// ST_DRAIN | length overrun; beats are discarded unchecked until tlast
module axis_pattern_checker #(
   parameter int DATA_WIDTH = 16,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  aclk,
   input  logic                  areset,
   axis_pattern_checker_if.slave s,
   input  logic                  enable,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] seed,
   input  logic [LEN_WIDTH-1:0]  pkt_len,
   output logic [31:0]           pkt_count,
   output logic [31:0]           err_count,
   output logic                  err_data,
   output logic                  err_len,
   output logic                  busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] exp_q, exp_d, exp_cur;
   logic [LEN_WIDTH-1:0]  idx_q, idx_d, idx_cur;
   logic [LEN_WIDTH-1:0]  len_q, len_d, len_cur;
   logic                  bad_q, bad_d, bad_cur;
   logic                  tready_q;
   logic                  throttle_ok;
   logic                  accept;
   logic                  mismatch;
   logic                  at_last;
   logic                  pkt_end;
   logic                  pkt_bad;
   logic                  set_err_data;
   logic                  set_err_len;

   assign accept   = s.tvalid & tready_q;
   assign s.tready = tready_q;
   assign busy     = (state_q != ST_IDLE);

`ifdef AXIS_CHK_THROTTLE_EN
   // Fibonacci LFSR, taps 16,14,13,11; free-running so the ready pattern is reproducible from reset.
   logic [15:0] lfsr_q;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
   end

   assign throttle_ok = (lfsr_q[1:0] != 2'b00);
`else
   assign throttle_ok = 1'b1;
`endif

   // A packet's seed and length are taken from the ports only on its first beat.
   always_comb begin
      exp_cur = exp_q;
      idx_cur = idx_q;
      len_cur = len_q;
      bad_cur = bad_q;
      if (state_q == ST_IDLE) begin
         exp_cur = seed;
         idx_cur = '0;
         len_cur = (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
         bad_cur = 1'b0;
      end
   end

   assign mismatch = (s.tdata != exp_cur);
   assign at_last  = (idx_cur == (len_cur - LEN_WIDTH'(1)));

   always_comb begin
      state_d      = state_q;
      exp_d        = exp_q;
      idx_d        = idx_q;
      len_d        = len_q;
      bad_d        = bad_q;
      pkt_end      = 1'b0;
      pkt_bad      = 1'b0;
      set_err_data = 1'b0;
      set_err_len  = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_RECV: begin
            if (accept) begin
               set_err_data = mismatch;
               exp_d        = exp_cur + DATA_WIDTH'(1);
               len_d        = len_cur;
               if (s.tlast) begin
                  pkt_end     = 1'b1;
                  set_err_len = ~at_last;
                  pkt_bad     = bad_cur | mismatch | ~at_last;
                  idx_d       = '0;
                  bad_d       = 1'b0;
                  state_d     = ST_IDLE;
               end else if (at_last) begin
                  // Length reached without tlast: the rest of the packet is junk.
                  set_err_len = 1'b1;
                  idx_d       = '0;
                  bad_d       = 1'b1;
                  state_d     = ST_DRAIN;
               end else begin
                  idx_d   = idx_cur + LEN_WIDTH'(1);
                  bad_d   = bad_cur | mismatch;
                  state_d = ST_RECV;
               end
            end
         end
         ST_DRAIN: begin
            if (accept && s.tlast) begin
               pkt_end = 1'b1;
               pkt_bad = 1'b1;
               bad_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q   <= ST_IDLE;
         exp_q     <= '0;
         idx_q     <= '0;
         len_q     <= '0;
         bad_q     <= 1'b0;
         pkt_count <= '0;
         err_count <= '0;
         err_data  <= 1'b0;
         err_len   <= 1'b0;
      end else if (clear) begin
         // Clear outranks a beat accepted in the same cycle; that beat is dropped.
         state_q   <= ST_IDLE;
         exp_q     <= '0;
         idx_q     <= '0;
         len_q     <= '0;
         bad_q     <= 1'b0;
         pkt_count <= '0;
         err_count <= '0;
         err_data  <= 1'b0;
         err_len   <= 1'b0;
      end else begin
         state_q <= state_d;
         exp_q   <= exp_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         bad_q   <= bad_d;
         if (pkt_end && (pkt_count != 32'hFFFF_FFFF)) begin
            pkt_count <= pkt_count + 32'd1;
         end
         if (pkt_end && pkt_bad && (err_count != 32'hFFFF_FFFF)) begin
            err_count <= err_count + 32'd1;
         end
         if (set_err_data) begin
            err_data <= 1'b1;
         end
         if (set_err_len) begin
            err_len <= 1'b1;
         end
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         tready_q <= 1'b0;
      end else begin
         tready_q <= enable & ~clear & throttle_ok;
      end
   end

endmodule

// File: tb/tb_axis_pattern_checker.sv
// Randomized and directed bench for axis_pattern_checker with a packet-level reference model.
// Define AXIS_CHK_THROTTLE_EN for both RTL and bench to exercise the backpressure generator.
module tb_axis_pattern_checker;
   localparam int DW = 16;
   localparam int LW = 16;

   logic          aclk = 1'b0;
   logic          areset = 1'b1;
   logic          enable = 1'b0;
   logic          clear = 1'b0;
   logic [DW-1:0] seed = '0;
   logic [LW-1:0] pkt_len = '0;
   logic [31:0]   pkt_count;
   logic [31:0]   err_count;
   logic          err_data;
   logic          err_len;
   logic          busy;

   always #5 aclk = ~aclk;

   axis_pattern_checker_if #(.DATA_WIDTH(DW)) bus ();

   axis_pattern_checker #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .aclk      (aclk),
      .areset    (areset),
      .s         (bus),
      .enable    (enable),
      .clear     (clear),
      .seed      (seed),
      .pkt_len   (pkt_len),
      .pkt_count (pkt_count),
      .err_count (err_count),
      .err_data  (err_data),
      .err_len   (err_len),
      .busy      (busy)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: whole-packet view of the checker's counters and flags.
   longint unsigned m_pkt;
   longint unsigned m_err;
   bit              m_err_data;
   bit              m_err_len;
   logic [DW-1:0]   beat_q[$];

   task automatic model_reset();
      m_pkt = 0;
      m_err = 0;
      m_err_data = 0;
      m_err_len = 0;
   endtask

   // A packet of n beats against length L: the first min(n,L) beats must equal seed+i,
   // and n must equal L; any violation makes the packet bad.
   task automatic model_packet(input logic [DW-1:0] sd, input int unsigned len);
      int unsigned   eff_len;
      int unsigned   n;
      bit            data_bad;
      bit            len_bad;
      logic [DW-1:0] want;
      eff_len = (len == 0) ? 1 : len;
      n = beat_q.size();
      data_bad = 0;
      for (int i = 0; i < n && i < eff_len; i++) begin
         want = sd + DW'(i);
         if (beat_q[i] != want) data_bad = 1;
      end
      len_bad = (n != eff_len);
      if (m_pkt < 64'hFFFF_FFFF) m_pkt++;
      if ((data_bad || len_bad) && m_err < 64'hFFFF_FFFF) m_err++;
      m_err_data |= data_bad;
      m_err_len |= len_bad;
   endtask

   // Called at a falling edge; returns at the falling edge after the beat is taken.
   task automatic send_beat(input logic [DW-1:0] d, input logic last);
      int n;
      bus.tdata = d;
      bus.tlast = last;
      bus.tvalid = 1'b1;
      n = 0;
      while (bus.tready !== 1'b1 && n < 100) begin
         @(negedge aclk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL beat_timeout tready never rose for data %h", d);
      end
      @(negedge aclk);
   endtask

   task automatic send_packet(input logic [DW-1:0] sd, input int unsigned len, input bit gaps);
      seed = sd;
      pkt_len = LW'(len);
      for (int i = 0; i < beat_q.size(); i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            bus.tvalid = 1'b0;
            bus.tdata = DW'($urandom);
            bus.tlast = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge aclk);
         end
         send_beat(beat_q[i], i == beat_q.size() - 1);
      end
      bus.tvalid = 1'b0;
      bus.tlast = 1'b0;
      model_packet(sd, len);
   endtask

   task automatic fill_incr(input logic [DW-1:0] sd, input int n);
      beat_q.delete();
      for (int i = 0; i < n; i++) beat_q.push_back(sd + DW'(i));
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge aclk);
      clear = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      areset = 1'b1;
      enable = 1'b0;
      bus.tvalid = 1'b0;
      bus.tlast = 1'b0;
      bus.tdata = '0;
      #1;
      checks++;
      if (bus.tready !== 1'b0) begin
         errors++;
         $display("FAIL reset_tready got %b want 0", bus.tready);
      end
      checks++;
      if (pkt_count !== 32'd0 || err_count !== 32'd0) begin
         errors++;
         $display("FAIL reset_counts got %0d/%0d want 0/0", pkt_count, err_count);
      end
      checks++;
      if ({err_data, err_len, busy} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags got %b want 000", {err_data, err_len, busy});
      end
      @(negedge aclk);
      areset = 1'b0;
      enable = 1'b1;
      model_reset();
      @(negedge aclk);
      checks++;
      if (bus.tready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready_after_enable got %b want 1", bus.tready);
      end
   endtask

   task automatic test_clean();
      do_clear();
      for (int p = 0; p < 3; p++) begin
         fill_incr(16'h0010, 4);
         send_packet(16'h0010, 4, 0);
      end
      checks++;
      if (pkt_count !== 32'd3 || err_count !== 32'd0) begin
         errors++;
         $display("FAIL clean_counts got %0d/%0d want 3/0", pkt_count, err_count);
      end
      checks++;
      if (err_data !== 1'b0 || err_len !== 1'b0) begin
         errors++;
         $display("FAIL clean_flags got %b%b want 00", err_data, err_len);
      end
   endtask

   task automatic test_data_error();
      do_clear();
      for (int p = 0; p < 3; p++) begin
         fill_incr(16'h0010, 4);
         if (p == 1) beat_q[1] = 16'hDEAD;
         send_packet(16'h0010, 4, 0);
      end
      checks++;
      if (pkt_count !== 32'd3 || err_count !== 32'd1) begin
         errors++;
         $display("FAIL data_err_counts got %0d/%0d want 3/1", pkt_count, err_count);
      end
      checks++;
      if (err_data !== 1'b1 || err_len !== 1'b0) begin
         errors++;
         $display("FAIL data_err_flags got %b%b want 10", err_data, err_len);
      end
   endtask

   task automatic test_len_errors();
      do_clear();
      fill_incr(16'h0010, 2);
      send_packet(16'h0010, 4, 0);
      checks++;
      if (err_len !== 1'b1 || busy !== 1'b0 || pkt_count !== 32'd1 || err_count !== 32'd1) begin
         errors++;
         $display("FAIL early_tlast got len=%b busy=%b pkt=%0d err=%0d want 1 0 1 1",
                  err_len, busy, pkt_count, err_count);
      end
      seed = 16'h0010;
      pkt_len = 16'd4;
      for (int i = 0; i < 4; i++) send_beat(16'h0010 + DW'(i), 1'b0);
      send_beat(16'hBEEF, 1'b0);
      checks++;
      if (busy !== 1'b1 || pkt_count !== 32'd1) begin
         errors++;
         $display("FAIL drain_busy got busy=%b pkt=%0d want 1 1", busy, pkt_count);
      end
      send_beat(16'h5A5A, 1'b1);
      bus.tvalid = 1'b0;
      bus.tlast = 1'b0;
      checks++;
      if (pkt_count !== 32'd2 || err_count !== 32'd2 || err_data !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL drain_end got pkt=%0d err=%0d data=%b busy=%b want 2 2 0 0",
                  pkt_count, err_count, err_data, busy);
      end
      m_pkt = 2;
      m_err = 2;
      m_err_len = 1;
   endtask

   task automatic test_wrap();
      do_clear();
      fill_incr(16'hFFFE, 3);
      send_packet(16'hFFFE, 3, 0);
      checks++;
      if (pkt_count !== 32'd1 || err_count !== 32'd0 || err_data !== 1'b0) begin
         errors++;
         $display("FAIL wrap got pkt=%0d err=%0d data=%b want 1 0 0", pkt_count, err_count, err_data);
      end
      fill_incr(16'h1234, 1);
      send_packet(16'h1234, 0, 0);
      checks++;
      if (pkt_count !== 32'd2 || err_count !== 32'd0 || err_len !== 1'b0) begin
         errors++;
         $display("FAIL len0_single got pkt=%0d err=%0d len=%b want 2 0 0", pkt_count, err_count, err_len);
      end
      fill_incr(16'h0777, 2);
      send_packet(16'h0777, 1, 0);
      checks++;
      if (pkt_count !== 32'd3 || err_count !== 32'd1 || err_len !== 1'b1 || err_data !== 1'b0) begin
         errors++;
         $display("FAIL len1_missing got pkt=%0d err=%0d len=%b data=%b want 3 1 1 0",
                  pkt_count, err_count, err_len, err_data);
      end
   endtask

   task automatic test_stall();
      int bad_cycles;
      do_clear();
      seed = 16'h0100;
      pkt_len = 16'd4;
      send_beat(16'h0100, 1'b0);
      send_beat(16'h0101, 1'b0);
      bus.tvalid = 1'b0;
      enable = 1'b0;
      @(negedge aclk);
      bus.tvalid = 1'b1;
      bus.tdata = 16'h0102;
      bus.tlast = 1'b0;
      bad_cycles = 0;
      for (int c = 0; c < 5; c++) begin
         if (bus.tready !== 1'b0 || busy !== 1'b1) bad_cycles++;
         @(negedge aclk);
      end
      checks++;
      if (bad_cycles != 0) begin
         errors++;
         $display("FAIL stall_ready got %0d cycles with tready/busy wrong want 0", bad_cycles);
      end
      enable = 1'b1;
      send_beat(16'h0102, 1'b0);
      send_beat(16'h0103, 1'b1);
      bus.tvalid = 1'b0;
      bus.tlast = 1'b0;
      checks++;
      if (pkt_count !== 32'd1 || err_count !== 32'd0 || err_data !== 1'b0 || err_len !== 1'b0) begin
         errors++;
         $display("FAIL stall_resume got pkt=%0d err=%0d flags=%b%b want 1 0 00",
                  pkt_count, err_count, err_data, err_len);
      end
      m_pkt = 1;
   endtask

   task automatic test_clear();
      int n;
      fill_incr(16'h0000, 2);
      beat_q[1] = 16'h0005;
      send_packet(16'h0000, 2, 0);
      seed = 16'h0000;
      pkt_len = 16'd4;
      send_beat(16'h0000, 1'b0);
      n = 0;
      while (bus.tready !== 1'b1 && n < 50) begin
         @(negedge aclk);
         n++;
      end
      bus.tvalid = 1'b1;
      bus.tdata = 16'h0001;
      bus.tlast = 1'b0;
      clear = 1'b1;
      @(negedge aclk);
      checks++;
      if (pkt_count !== 32'd0 || err_count !== 32'd0 || err_data !== 1'b0 || err_len !== 1'b0 ||
          busy !== 1'b0 || bus.tready !== 1'b0) begin
         errors++;
         $display("FAIL clear_beat got pkt=%0d err=%0d flags=%b%b busy=%b tready=%b want all 0",
                  pkt_count, err_count, err_data, err_len, busy, bus.tready);
      end
      clear = 1'b0;
      bus.tvalid = 1'b0;
      model_reset();
      @(negedge aclk);
      fill_incr(16'h0020, 2);
      send_packet(16'h0020, 2, 0);
      checks++;
      if (pkt_count !== 32'd1 || err_count !== 32'd0 || err_data !== 1'b0) begin
         errors++;
         $display("FAIL clear_then_packet got pkt=%0d err=%0d data=%b want 1 0 0",
                  pkt_count, err_count, err_data);
      end
   endtask

   task automatic test_areset();
      seed = 16'h0040;
      pkt_len = 16'd4;
      send_beat(16'h0040, 1'b0);
      send_beat(16'h0047, 1'b0);
      bus.tvalid = 1'b0;
      #2 areset = 1'b1;
      #1;
      checks++;
      if (pkt_count !== 32'd0 || err_count !== 32'd0 || err_data !== 1'b0 || err_len !== 1'b0 ||
          busy !== 1'b0 || bus.tready !== 1'b0) begin
         errors++;
         $display("FAIL areset_mid got pkt=%0d err=%0d flags=%b%b busy=%b tready=%b want all 0",
                  pkt_count, err_count, err_data, err_len, busy, bus.tready);
      end
      @(negedge aclk);
      areset = 1'b0;
      model_reset();
      fill_incr(16'h0050, 3);
      send_packet(16'h0050, 3, 0);
      checks++;
      if (pkt_count !== 32'd1 || err_count !== 32'd0 || err_data !== 1'b0 || err_len !== 1'b0) begin
         errors++;
         $display("FAIL areset_recover got pkt=%0d err=%0d flags=%b%b want 1 0 00",
                  pkt_count, err_count, err_data, err_len);
      end
   endtask

   task automatic test_random();
      logic [DW-1:0] sd;
      int unsigned   len;
      int            eff_len;
      int            n;
      do_clear();
      for (int p = 0; p < 40; p++) begin
         sd = DW'($urandom);
         len = $urandom_range(0, 6);
         eff_len = (len == 0) ? 1 : int'(len);
         n = eff_len;
         if ($urandom_range(0, 1) == 1) n = eff_len + int'($urandom_range(0, 4)) - 2;
         if (n < 1) n = 1;
         fill_incr(sd, n);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) == 0) beat_q[i] = beat_q[i] ^ DW'($urandom_range(1, 16'hFFFF));
         end
         send_packet(sd, len, 1);
         checks++;
         if (pkt_count !== m_pkt[31:0] || err_count !== m_err[31:0]) begin
            errors++;
            $display("FAIL random_counts pkt %0d got %0d/%0d want %0d/%0d",
                     p, pkt_count, err_count, m_pkt, m_err);
         end
         checks++;
         if (err_data !== m_err_data || err_len !== m_err_len) begin
            errors++;
            $display("FAIL random_flags pkt %0d got %b%b want %b%b",
                     p, err_data, err_len, m_err_data, m_err_len);
         end
      end
   endtask

`ifdef AXIS_CHK_THROTTLE_EN
   task automatic test_throttle();
      logic [15:0] m_lfsr;
      logic        m_ready;
      logic        nxt;
      bit          acc;
      int          beats;
      int          cycles;
      int          ready_cycles;
      int          mism;
      int          duty;
      areset = 1'b1;
      enable = 1'b1;
      bus.tvalid = 1'b0;
      @(negedge aclk);
      areset = 1'b0;
      model_reset();
      seed = 16'h0000;
      pkt_len = 16'd4;
      m_lfsr = 16'hACE1;
      m_ready = 1'b0;
      beats = 0;
      cycles = 0;
      ready_cycles = 0;
      mism = 0;
      bus.tdata = 16'h0000;
      bus.tlast = 1'b0;
      bus.tvalid = 1'b1;
      while (beats < 1000 && cycles < 3000) begin
         if (bus.tready !== m_ready) mism++;
         if (m_ready) ready_cycles++;
         cycles++;
         acc = m_ready;
         @(posedge aclk);
         nxt = (m_lfsr[1:0] != 2'b00);
         m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
         m_ready = nxt;
         @(negedge aclk);
         if (acc) begin
            beats++;
            bus.tdata = DW'(beats % 4);
            bus.tlast = ((beats % 4) == 3);
         end
      end
      bus.tvalid = 1'b0;
      bus.tlast = 1'b0;
      checks++;
      if (mism != 0 || beats < 1000) begin
         errors++;
         $display("FAIL throttle_sequence got %0d ready mismatches, %0d beats want 0, 1000", mism, beats);
      end
      duty = (ready_cycles * 100) / ((cycles == 0) ? 1 : cycles);
      checks++;
      if (duty < 70 || duty > 80) begin
         errors++;
         $display("FAIL throttle_duty got %0d percent want 70..80", duty);
      end
      checks++;
      if (pkt_count !== 32'd250 || err_count !== 32'd0 || err_data !== 1'b0 || err_len !== 1'b0) begin
         errors++;
         $display("FAIL throttle_counts got pkt=%0d err=%0d flags=%b%b want 250 0 00",
                  pkt_count, err_count, err_data, err_len);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_clean();
      test_data_error();
      test_len_errors();
      test_wrap();
      test_stall();
      test_clear();
      test_areset();
      test_random();
`ifdef AXIS_CHK_THROTTLE_EN
      test_throttle();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

endmodule
